// File: rtl/spi_sensor_reader_pkg.sv
// Shared definitions for the SPI sensor reader: FSM states, default SPI timing
// and a counter-width helper that never returns a zero-width vector.
package spi_sensor_reader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    DONE
  } state_e;

  localparam int DEF_CLK_DIV       = 2;
  localparam int DEF_SAMPLE_PERIOD = 50000;
  localparam int DEF_FRAME_BITS    = 16;
  localparam int SAMPLE_W          = 16;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK half-period generator: counts CLK_DIV cycles per phase while running and
// toggles a registered SCLK level at the end of each phase when asked to.
module spi_clk_gen
  import spi_sensor_reader_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  input  logic toggle_en_i,
  output logic phase_end_o,
  output logic sclk_o
);

  localparam int CW = cnt_width(CLK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;

  always_comb begin
    phase_end_o = run_i && (cnt_q == CW'(CLK_DIV - 1));
    cnt_d       = cnt_q + CW'(1);
    if (!run_i || phase_end_o) begin
      cnt_d = '0;
    end
    // SCLK falls back to idle-low whenever the frame is not running
    sclk_d = sclk_q;
    if (!run_i) begin
      sclk_d = 1'b0;
    end else if (toggle_en_i && phase_end_o) begin
      sclk_d = ~sclk_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o = sclk_q;

endmodule

// File: rtl/spi_sensor_reader.sv
// Mode-0 SPI master that periodically reads one frame from an external sensor
// and presents the right-aligned sample with a one-cycle ready pulse.
module spi_sensor_reader
  import spi_sensor_reader_pkg::*;
#(
  parameter int CLK_DIV       = DEF_CLK_DIV,
  parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD,
  parameter int FRAME_BITS    = DEF_FRAME_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                spi_miso,
  output logic                spi_sclk,
  output logic                spi_cs_n,
  output logic [SAMPLE_W-1:0] sensor_out,
  output logic                sensorready
);

  localparam int TW = cnt_width(SAMPLE_PERIOD);
  localparam int BW = cnt_width(FRAME_BITS);

  state_e                state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  pending_q, pending_d;
  logic [SAMPLE_W-1:0]   shift_q, shift_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [SAMPLE_W-1:0]   sensor_q, sensor_d;
  logic                  cs_n_q, cs_n_d;
  logic                  ready_q, ready_d;
  logic                  miso_meta_q, miso_sync_q;

  logic phase_end;
  logic sclk;
  logic run;
  logic expire;
  logic start;
  logic high_end;
  logic last_bit;

  assign run = (state_q == CS_SETUP) || (state_q == SHIFT) || (state_q == CS_HOLD);

  spi_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk        (clk),
    .rst        (rst),
    .run_i      (run),
    .toggle_en_i(state_q == SHIFT),
    .phase_end_o(phase_end),
    .sclk_o     (sclk)
  );

  always_comb begin
    expire   = enable && (timer_q == TW'(SAMPLE_PERIOD - 1));
    start    = (state_q == IDLE) && pending_q && enable;
    high_end = (state_q == SHIFT) && phase_end && sclk;
    last_bit = high_end && (bit_q == BW'(FRAME_BITS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cs_n_q  <= 1'b1;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cs_n_q  <= cs_n_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (start)     state_d = CS_SETUP;
      CS_SETUP: if (phase_end) state_d = SHIFT;
      SHIFT:    if (last_bit)  state_d = CS_HOLD;
      CS_HOLD:  if (phase_end) state_d = DONE;
      DONE:                    state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Decoded from the next state so the flopped pins line up with state_q
  always_comb begin
    cs_n_d  = !((state_d == CS_SETUP) || (state_d == SHIFT) || (state_d == CS_HOLD));
    ready_d = (state_d == DONE);
  end

  // A new expiry wins over the clear so nothing is lost on the start cycle
  always_comb begin
    timer_d = timer_q;
    if (enable) begin
      timer_d = expire ? '0 : timer_q + TW'(1);
    end
    pending_d = expire | (pending_q & ~start);

    shift_d = shift_q;
    bit_d   = bit_q;
    if (start) begin
      shift_d = '0;
      bit_d   = '0;
    end else if (high_end) begin
      shift_d = {shift_q[SAMPLE_W-2:0], miso_sync_q};
      bit_d   = bit_q + BW'(1);
    end

    sensor_d = (state_d == DONE) ? shift_q : sensor_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q     <= '0;
      pending_q   <= 1'b0;
      shift_q     <= '0;
      bit_q       <= '0;
      sensor_q    <= '0;
      miso_meta_q <= 1'b0;
      miso_sync_q <= 1'b0;
    end else begin
      timer_q     <= timer_d;
      pending_q   <= pending_d;
      shift_q     <= shift_d;
      bit_q       <= bit_d;
      sensor_q    <= sensor_d;
      miso_meta_q <= spi_miso;
      miso_sync_q <= miso_meta_q;
    end
  end

  assign spi_sclk    = sclk;
  assign spi_cs_n    = cs_n_q;
  assign sensor_out  = sensor_q;
  assign sensorready = ready_q;

endmodule

// File: tb/tb_spi_sensor_reader.sv
// Directed bench for spi_sensor_reader: three instances (period 200, period 10,
// 12-bit frames) each driven by a mode-0 slave model that shifts on SCLK fall.
module tb_spi_sensor_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstA, enA, misoA, sclkA, csA, readyA;
  logic        rstB, enB, misoB, sclkB, csB, readyB;
  logic        rstC, enC, misoC, sclkC, csC, readyC;
  logic [15:0] outA, outB, outC;
  logic [15:0] wordA, wordB, wordC;
  int          bitA, bitB, bitC;
  logic [15:0] b2bWords [5];

  int compared   = 0;
  int mismatched = 0;

  spi_sensor_reader #(.CLK_DIV(2), .SAMPLE_PERIOD(200), .FRAME_BITS(16)) dutA (
    .clk(clk), .rst(rstA), .enable(enA), .spi_miso(misoA),
    .spi_sclk(sclkA), .spi_cs_n(csA), .sensor_out(outA), .sensorready(readyA)
  );

  spi_sensor_reader #(.CLK_DIV(2), .SAMPLE_PERIOD(10), .FRAME_BITS(16)) dutB (
    .clk(clk), .rst(rstB), .enable(enB), .spi_miso(misoB),
    .spi_sclk(sclkB), .spi_cs_n(csB), .sensor_out(outB), .sensorready(readyB)
  );

  spi_sensor_reader #(.CLK_DIV(2), .SAMPLE_PERIOD(200), .FRAME_BITS(12)) dutC (
    .clk(clk), .rst(rstC), .enable(enC), .spi_miso(misoC),
    .spi_sclk(sclkC), .spi_cs_n(csC), .sensor_out(outC), .sensorready(readyC)
  );

  // Slave models: MSB on chip-select fall, next bit on each SCLK fall
  always @(negedge csA) begin bitA = 15; misoA = wordA[15]; end
  always @(negedge sclkA) if (csA === 1'b0 && bitA > 0) begin bitA = bitA - 1; misoA = wordA[bitA[3:0]]; end
  always @(negedge csB) begin bitB = 15; misoB = wordB[15]; end
  always @(negedge sclkB) if (csB === 1'b0 && bitB > 0) begin bitB = bitB - 1; misoB = wordB[bitB[3:0]]; end
  always @(negedge csC) begin bitC = 11; misoC = wordC[11]; end
  always @(negedge sclkC) if (csC === 1'b0 && bitC > 0) begin bitC = bitC - 1; misoC = wordC[bitC[3:0]]; end

  function automatic logic csOf(input int s);
    case (s)
      0:       return csA;
      1:       return csB;
      default: return csC;
    endcase
  endfunction

  function automatic logic sclkOf(input int s);
    case (s)
      0:       return sclkA;
      1:       return sclkB;
      default: return sclkC;
    endcase
  endfunction

  function automatic logic readyOf(input int s);
    case (s)
      0:       return readyA;
      1:       return readyB;
      default: return readyC;
    endcase
  endfunction

  function automatic logic [15:0] outOf(input int s);
    case (s)
      0:       return outA;
      1:       return outB;
      default: return outC;
    endcase
  endfunction

  task automatic wait_cs_low(input int s, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (csOf(s) === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ready(input int s, input int budget, output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      n++;
      if (readyOf(s) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Entered on the first cycle with cs_n low; returns on the cycle cs_n rises
  task automatic measure_frame(input int s, output int low, output int rises,
                               output logic rdy, output logic [15:0] data);
    logic prev;
    low   = 1;
    rises = 0;
    prev  = sclkOf(s);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (csOf(s) !== 1'b0) break;
      low++;
      if (sclkOf(s) === 1'b1 && prev === 1'b0) rises++;
      prev = sclkOf(s);
    end
    rdy  = readyOf(s);
    data = outOf(s);
  endtask

  task automatic test_reset();
    rstA = 1'b1;
    enA  = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if (sclkA !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_sclk: got %b, expected 0", sclkA); end
    compared++;
    if (csA !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_cs_n: got %b, expected 1", csA); end
    compared++;
    if (outA !== 16'h0000) begin mismatched++; $display("[TB] FAIL reset_sensor_out: got %h, expected 0000", outA); end
    compared++;
    if (readyA !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ready: got %b, expected 0", readyA); end
    rstA = 1'b0;
    enA  = 1'b1;
  endtask

  task automatic test_single_frame();
    bit ok;
    int low, rises;
    logic rdy;
    logic [15:0] data;
    wordA = 16'hA5C3;
    wait_cs_low(0, 400, ok);
    compared++;
    if (!ok) begin mismatched++; $display("[TB] FAIL single_start: got no frame, expected cs_n low within 400 cycles"); end
    measure_frame(0, low, rises, rdy, data);
    compared++;
    if (low !== 68) begin mismatched++; $display("[TB] FAIL single_cs_low: got %0d, expected 68", low); end
    compared++;
    if (rises !== 16) begin mismatched++; $display("[TB] FAIL single_sclk_rises: got %0d, expected 16", rises); end
    compared++;
    if (rdy !== 1'b1) begin mismatched++; $display("[TB] FAIL single_ready: got %b, expected 1", rdy); end
    compared++;
    if (data !== 16'hA5C3) begin mismatched++; $display("[TB] FAIL single_data: got %h, expected a5c3", data); end
    @(negedge clk);
    compared++;
    if (readyA !== 1'b0) begin mismatched++; $display("[TB] FAIL single_ready_width: got %b, expected 0", readyA); end
  endtask

  task automatic test_patterns();
    bit ok;
    int n;
    wordA = 16'h0000;
    wait_ready(0, 300, n, ok);
    compared++;
    if (!ok) begin mismatched++; $display("[TB] FAIL pattern0_ready: got none, expected a pulse"); end
    compared++;
    if (outA !== 16'h0000) begin mismatched++; $display("[TB] FAIL pattern0_data: got %h, expected 0000", outA); end
    wordA = 16'hFFFF;
    wait_ready(0, 300, n, ok);
    compared++;
    if (!ok) begin mismatched++; $display("[TB] FAIL patternF_ready: got none, expected a pulse"); end
    compared++;
    if (outA !== 16'hFFFF) begin mismatched++; $display("[TB] FAIL patternF_data: got %h, expected ffff", outA); end
    compared++;
    if (n !== 200) begin mismatched++; $display("[TB] FAIL pattern_spacing: got %0d, expected 200", n); end
  endtask

  task automatic test_reset_abort();
    bit ok;
    int readyCount, lowCount;
    wait_cs_low(0, 300, ok);
    compared++;
    if (!ok) begin mismatched++; $display("[TB] FAIL abort_start: got no frame, expected cs_n low"); end
    repeat (30) @(negedge clk);
    rstA = 1'b1;
    @(negedge clk);
    compared++;
    if (csA !== 1'b1) begin mismatched++; $display("[TB] FAIL abort_cs_n: got %b, expected 1", csA); end
    compared++;
    if (sclkA !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_sclk: got %b, expected 0", sclkA); end
    compared++;
    if (outA !== 16'h0000) begin mismatched++; $display("[TB] FAIL abort_sensor_out: got %h, expected 0000", outA); end
    compared++;
    if (readyA !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_ready: got %b, expected 0", readyA); end
    rstA = 1'b0;
    readyCount = 0;
    lowCount   = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (readyA === 1'b1) readyCount++;
      if (csA !== 1'b1) lowCount++;
    end
    compared++;
    if (readyCount !== 0) begin mismatched++; $display("[TB] FAIL abort_no_ready: got %0d pulses, expected 0", readyCount); end
    compared++;
    if (lowCount !== 0) begin mismatched++; $display("[TB] FAIL abort_no_frame: got %0d low cycles, expected 0", lowCount); end
  endtask

  task automatic test_enable_drop();
    bit ok;
    int n, lowCount;
    wordA = 16'h3C5A;
    wait_cs_low(0, 400, ok);
    compared++;
    if (!ok) begin mismatched++; $display("[TB] FAIL endrop_start: got no frame, expected cs_n low"); end
    repeat (10) @(negedge clk);
    enA = 1'b0;
    wait_ready(0, 200, n, ok);
    compared++;
    if (!ok) begin mismatched++; $display("[TB] FAIL endrop_ready: got none, expected frame to complete"); end
    compared++;
    if (outA !== 16'h3C5A) begin mismatched++; $display("[TB] FAIL endrop_data: got %h, expected 3c5a", outA); end
    lowCount = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (csA !== 1'b1) lowCount++;
    end
    compared++;
    if (lowCount !== 0) begin mismatched++; $display("[TB] FAIL endrop_no_frame: got %0d low cycles, expected 0", lowCount); end
    enA = 1'b1;
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      n++;
      if (csA === 1'b0) break;
    end
    compared++;
    if (n !== 190) begin mismatched++; $display("[TB] FAIL endrop_resume: got %0d cycles, expected 190", n); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int low, rises, gap;
    logic rdy;
    logic [15:0] data;
    rstB  = 1'b1;
    enB   = 1'b0;
    wordB = b2bWords[0];
    repeat (2) @(negedge clk);
    rstB = 1'b0;
    enB  = 1'b1;
    wait_cs_low(1, 100, ok);
    compared++;
    if (!ok) begin mismatched++; $display("[TB] FAIL b2b_start: got no frame, expected cs_n low"); end
    for (int k = 0; k < 5; k++) begin
      measure_frame(1, low, rises, rdy, data);
      if (k < 4) wordB = b2bWords[k + 1];
      compared++;
      if (low !== 68) begin mismatched++; $display("[TB] FAIL b2b_cs_low[%0d]: got %0d, expected 68", k, low); end
      compared++;
      if (rdy !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_ready[%0d]: got %b, expected 1", k, rdy); end
      compared++;
      if (data !== b2bWords[k]) begin mismatched++; $display("[TB] FAIL b2b_data[%0d]: got %h, expected %h", k, data, b2bWords[k]); end
      gap = 1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (csB === 1'b0) break;
        gap++;
      end
      compared++;
      if (gap !== 2) begin mismatched++; $display("[TB] FAIL b2b_gap[%0d]: got %0d high cycles, expected 2", k, gap); end
    end
  endtask

  task automatic test_frame_bits();
    bit ok;
    int low, rises;
    logic rdy;
    logic [15:0] data;
    rstC  = 1'b1;
    enC   = 1'b0;
    wordC = 16'h0ABC;
    repeat (2) @(negedge clk);
    rstC = 1'b0;
    enC  = 1'b1;
    wait_cs_low(2, 400, ok);
    compared++;
    if (!ok) begin mismatched++; $display("[TB] FAIL fb12_start: got no frame, expected cs_n low"); end
    measure_frame(2, low, rises, rdy, data);
    compared++;
    if (low !== 52) begin mismatched++; $display("[TB] FAIL fb12_cs_low: got %0d, expected 52", low); end
    compared++;
    if (rises !== 12) begin mismatched++; $display("[TB] FAIL fb12_sclk_rises: got %0d, expected 12", rises); end
    compared++;
    if (rdy !== 1'b1) begin mismatched++; $display("[TB] FAIL fb12_ready: got %b, expected 1", rdy); end
    compared++;
    if (data !== 16'h0ABC) begin mismatched++; $display("[TB] FAIL fb12_data: got %h, expected 0abc", data); end
  endtask

  initial begin
    rstA = 1'b1; enA = 1'b0; misoA = 1'b0; wordA = 16'h0000; bitA = 0;
    rstB = 1'b1; enB = 1'b0; misoB = 1'b0; wordB = 16'h0000; bitB = 0;
    rstC = 1'b1; enC = 1'b0; misoC = 1'b0; wordC = 16'h0000; bitC = 0;
    b2bWords[0] = 16'h1234;
    b2bWords[1] = 16'h8001;
    b2bWords[2] = 16'h7FFE;
    b2bWords[3] = 16'h0F0F;
    b2bWords[4] = 16'hC3A5;

    test_reset();
    test_single_frame();
    test_patterns();
    test_reset_abort();
    test_enable_drop();
    test_back_to_back();
    test_frame_bits();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
